// File: rtl/kvs_req_arbiter.sv
// rtl/kvs_req_arbiter.sv - N-port round-robin KVS request arbiter with in-order response routing
// Optional per-port grant/drop counters are built when KVS_ARB_STATS_EN is defined.
module kvs_req_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int KEY_SIZE   = 96,
    parameter int FLAG_SIZE  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*KEY_SIZE-1:0]  in_key,
    input  logic [NUM_PORTS*FLAG_SIZE-1:0] in_flag,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           res_valid,
    output logic [FLAG_SIZE-1:0]           res_flag,
    output logic [KEY_SIZE-1:0]            db_key,
    output logic [FLAG_SIZE-1:0]           db_flag,
    output logic                           db_valid,
    input  logic                           db_ready,
    input  logic                           db_out_valid,
    input  logic [FLAG_SIZE-1:0]           db_out_flag,
`ifdef KVS_ARB_STATS_EN
    output logic [NUM_PORTS*32-1:0]        req_cnt,
    output logic [NUM_PORTS*32-1:0]        drop_cnt,
`endif
    output logic [NUM_PORTS-1:0]           drop_pulse
);

    localparam int DW = KEY_SIZE + FLAG_SIZE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(MAX_OUTST);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DW-1:0]        w_head [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_nempty;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_drop;
    logic [PW-1:0]        w_gnt;
    logic                 w_found;
    logic                 w_load;
    logic                 w_grant;
    logic                 w_tag_pop;
    logic                 w_tag_full;
    logic                 w_tag_empty;

    logic [PW-1:0]        r_rr;
    logic                 r_db_valid;
    logic [KEY_SIZE-1:0]  r_db_key;
    logic [FLAG_SIZE-1:0] r_db_flag;
    logic [NUM_PORTS-1:0] r_res_valid;
    logic [FLAG_SIZE-1:0] r_res_flag;
    logic [NUM_PORTS-1:0] r_drop;
    logic [PW-1:0]        r_tag_mem [MAX_OUTST];
    logic [TW:0]          r_tag_wp;
    logic [TW:0]          r_tag_rp;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            logic [DW-1:0] r_mem [FIFO_DEPTH];
            logic [AW:0]   r_wp;
            logic [AW:0]   r_rp;
            logic          w_full;
            logic          w_push;

            assign w_full       = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
            assign w_nempty[gp] = (r_wp != r_rp);
            assign w_head[gp]   = r_mem[r_rp[AW-1:0]];
            assign w_pop[gp]    = w_grant && (w_gnt == PW'(gp));
            // A grant from a full FIFO frees its slot for this cycle's push
            assign w_push       = in_valid[gp] && (!w_full || w_pop[gp]);
            assign w_drop[gp]   = in_valid[gp] && !w_push;

            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wp[AW-1:0]] <= {in_key[gp*KEY_SIZE +: KEY_SIZE],
                                            in_flag[gp*FLAG_SIZE +: FLAG_SIZE]};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wp <= '0;
                    r_rp <= '0;
                end else begin
                    if (w_push)
                        r_wp <= r_wp + 1'b1;
                    if (w_pop[gp])
                        r_rp <= r_rp + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin : p_grant
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            v_idx = int'(r_rr) + i;
            if (v_idx >= NUM_PORTS)
                v_idx = v_idx - NUM_PORTS;
            if (!w_found && w_nempty[v_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = v_idx[PW-1:0];
            end
        end
    end

    assign w_tag_empty = (r_tag_wp == r_tag_rp);
    assign w_tag_full  = (r_tag_wp[TW] != r_tag_rp[TW]) && (r_tag_wp[TW-1:0] == r_tag_rp[TW-1:0]);
    assign w_tag_pop   = db_out_valid && !w_tag_empty;
    assign w_load      = !r_db_valid || db_ready;
    // A response retiring a tag this cycle makes room for the new grant's tag
    assign w_grant     = w_load && w_found && (!w_tag_full || w_tag_pop);

    always_ff @(posedge clk) begin
        if (w_grant)
            r_tag_mem[r_tag_wp[TW-1:0]] <= w_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr        <= '0;
            r_db_valid  <= 1'b0;
            r_db_key    <= '0;
            r_db_flag   <= '0;
            r_tag_wp    <= '0;
            r_tag_rp    <= '0;
            r_res_valid <= '0;
            r_res_flag  <= '0;
            r_drop      <= '0;
        end else begin
            if (w_load) begin
                r_db_valid <= w_grant;
                if (w_grant)
                    {r_db_key, r_db_flag} <= w_head[w_gnt];
            end
            if (w_grant) begin
                r_rr     <= (w_gnt == PW'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
                r_tag_wp <= r_tag_wp + 1'b1;
            end
            if (w_tag_pop) begin
                r_tag_rp    <= r_tag_rp + 1'b1;
                r_res_valid <= NUM_PORTS'(1) << r_tag_mem[r_tag_rp[TW-1:0]];
                r_res_flag  <= db_out_flag;
            end else begin
                r_res_valid <= '0;
            end
            r_drop <= w_drop;
        end
    end

    assign db_valid   = r_db_valid;
    assign db_key     = r_db_key;
    assign db_flag    = r_db_flag;
    assign res_valid  = r_res_valid;
    assign res_flag   = r_res_flag;
    assign drop_pulse = r_drop;

`ifdef KVS_ARB_STATS_EN
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_stats
            logic [31:0] r_req;
            logic [31:0] r_drp;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_req <= '0;
                    r_drp <= '0;
                end else begin
                    if (w_pop[gp] && (r_req != 32'hFFFF_FFFF))
                        r_req <= r_req + 1'b1;
                    if (w_drop[gp] && (r_drp != 32'hFFFF_FFFF))
                        r_drp <= r_drp + 1'b1;
                end
            end

            assign req_cnt[gp*32 +: 32]  = r_req;
            assign drop_cnt[gp*32 +: 32] = r_drp;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_kvs_req_arbiter.sv
// tb/tb_kvs_req_arbiter.sv - self-checking bench for kvs_req_arbiter against a queue-based model
module tb_kvs_req_arbiter;

    localparam int NP = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [191:0] in_key = '0;
    logic [7:0]   in_flag = '0;
    logic [1:0]   in_valid = '0;
    logic [1:0]   res_valid;
    logic [3:0]   res_flag;
    logic [95:0]  db_key;
    logic [3:0]   db_flag;
    logic         db_valid;
    logic         db_ready = 1'b0;
    logic         db_out_valid = 1'b0;
    logic [3:0]   db_out_flag = '0;
    logic [1:0]   drop_pulse;
`ifdef KVS_ARB_STATS_EN
    logic [63:0]  req_cnt;
    logic [63:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    kvs_req_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_key       (in_key),
        .in_flag      (in_flag),
        .in_valid     (in_valid),
        .res_valid    (res_valid),
        .res_flag     (res_flag),
        .db_key       (db_key),
        .db_flag      (db_flag),
        .db_valid     (db_valid),
        .db_ready     (db_ready),
        .db_out_valid (db_out_valid),
        .db_out_flag  (db_out_flag),
`ifdef KVS_ARB_STATS_EN
        .req_cnt      (req_cnt),
        .drop_cnt     (drop_cnt),
`endif
        .drop_pulse   (drop_pulse)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per-port request queues, one issue slot, a queue of outstanding port tags
    logic [99:0]  m_q0[$];
    logic [99:0]  m_q1[$];
    int           m_tag[$];
    bit           m_slot_v;
    logic [99:0]  m_slot;
    int           m_rr;
    logic [1:0]   m_res_v;
    logic [3:0]   m_res_flag;
    logic [1:0]   m_drop;
    int unsigned  m_req [2];
    int unsigned  m_drp [2];

    function automatic int qsz(input int p);
        return (p == 0) ? m_q0.size() : m_q1.size();
    endfunction

    task automatic model_reset();
        m_q0.delete();
        m_q1.delete();
        m_tag.delete();
        m_slot_v   = 1'b0;
        m_slot     = '0;
        m_rr       = 0;
        m_res_v    = '0;
        m_res_flag = '0;
        m_drop     = '0;
        for (int p = 0; p < NP; p++) begin
            m_req[p] = 0;
            m_drp[p] = 0;
        end
    endtask

    task automatic model_step();
        bit load, tpop, room, found, gr;
        int g;
        load  = !m_slot_v || db_ready;
        tpop  = db_out_valid && (m_tag.size() > 0);
        room  = (m_tag.size() < 8) || tpop;
        found = 1'b0;
        g     = 0;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (!found && qsz(p) > 0) begin
                found = 1'b1;
                g     = p;
            end
        end
        gr = load && found && room;
        if (tpop) begin
            int t;
            t          = m_tag.pop_front();
            m_res_v    = 2'(1 << t);
            m_res_flag = db_out_flag;
        end else begin
            m_res_v = '0;
        end
        if (gr) begin
            if (g == 0) m_slot = m_q0.pop_front();
            else        m_slot = m_q1.pop_front();
            m_tag.push_back(g);
            m_rr = (g + 1) % NP;
            m_req[g]++;
        end
        if (load)
            m_slot_v = gr;
        for (int p = 0; p < NP; p++) begin
            m_drop[p] = 1'b0;
            if (in_valid[p]) begin
                if (qsz(p) < 4) begin
                    if (p == 0) m_q0.push_back({in_key[p*96 +: 96], in_flag[p*4 +: 4]});
                    else        m_q1.push_back({in_key[p*96 +: 96], in_flag[p*4 +: 4]});
                end else begin
                    m_drop[p] = 1'b1;
                    m_drp[p]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("db_valid", db_valid, m_slot_v);
        if (m_slot_v) begin
            chk("db_key", db_key, m_slot[99:4]);
            chk("db_flag", db_flag, m_slot[3:0]);
        end
        chk("res_valid", res_valid, m_res_v);
        chk("res_flag", res_flag, m_res_flag);
        chk("drop_pulse", drop_pulse, m_drop);
`ifdef KVS_ARB_STATS_EN
        chk("req_cnt0", req_cnt[31:0], m_req[0]);
        chk("req_cnt1", req_cnt[63:32], m_req[1]);
        chk("drop_cnt0", drop_cnt[31:0], m_drp[0]);
        chk("drop_cnt1", drop_cnt[63:32], m_drp[1]);
`endif
    endtask

    task automatic step(input logic [1:0] v, input logic [191:0] k, input logic [7:0] f,
                        input logic rdy, input logic ov, input logic [3:0] of);
        in_valid     = v;
        in_key       = k;
        in_flag      = f;
        db_ready     = rdy;
        db_out_valid = ov;
        db_out_flag  = of;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [191:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input int n, input logic rdy, input logic ov);
        for (int i = 0; i < n; i++)
            step(2'b00, rkey(), 8'($urandom), rdy, ov, 4'($urandom));
    endtask

    int c0, c1;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_db_valid", db_valid, 1'b0);
        chk("rst_db_key", db_key, 96'h0);
        chk("rst_db_flag", db_flag, 4'h0);
        chk("rst_res_valid", res_valid, 2'b00);
        chk("rst_res_flag", res_flag, 4'h0);
        chk("rst_drop", drop_pulse, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // single request latency and response routing
        step(2'b01, {96'h0, 96'h1}, {4'h0, 4'h3}, 1'b1, 1'b0, 4'h0);
        chk("lat_t1_valid", db_valid, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0, 4'h0);
        chk("lat_t2_valid", db_valid, 1'b1);
        chk("lat_t2_key", db_key, 96'h1);
        chk("lat_t2_flag", db_flag, 4'h3);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'h9);
        chk("single_res_valid", res_valid, 2'b01);
        chk("single_res_flag", res_flag, 4'h9);
        idle(2, 1'b1, 1'b0);

        // fairness: flag carries the port number
        c0 = 0;
        c1 = 0;
        step(2'b11, rkey(), {4'h1, 4'h0}, 1'b1, 1'b1, 4'h2);
        for (int i = 0; i < 8; i++) begin
            step(2'b11, rkey(), {4'h1, 4'h0}, 1'b1, 1'b1, 4'h2);
            if (db_valid) begin
                if (db_flag == 4'h0) c0++;
                else                 c1++;
            end
        end
        chk("fair_p0", c0, 4);
        chk("fair_p1", c1, 4);
        idle(20, 1'b1, 1'b1);

        // overflow on port 1 with the db side stalled
        for (int i = 0; i < 6; i++) begin
            step(2'b10, rkey(), 8'($urandom), 1'b0, 1'b0, 4'h0);
            if (i == 4) chk("ovf_no_drop5", drop_pulse, 2'b00);
        end
        chk("ovf_drop6", drop_pulse, 2'b10);
        step(2'b10, rkey(), 8'($urandom), 1'b0, 1'b0, 4'h0);
        chk("ovf_drop7", drop_pulse, 2'b10);
        idle(20, 1'b1, 1'b1);

        // tag FIFO full: nine requests, no responses
        for (int i = 0; i < 9; i++)
            step(2'b01, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        idle(4, 1'b1, 1'b0);
        chk("tagfull_blocked", db_valid, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'h6);
        chk("tagfull_release", db_valid, 1'b1);
        idle(20, 1'b1, 1'b1);

        // ordering P0,P1,P1,P0
        step(2'b01, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b10, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b10, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b01, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        idle(2, 1'b1, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'hA);
        chk("ord_a_v", res_valid, 2'b01);
        chk("ord_a_f", res_flag, 4'hA);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'hB);
        chk("ord_b_v", res_valid, 2'b10);
        chk("ord_b_f", res_flag, 4'hB);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'hC);
        chk("ord_c_v", res_valid, 2'b10);
        chk("ord_c_f", res_flag, 4'hC);
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'hD);
        chk("ord_d_v", res_valid, 2'b01);
        chk("ord_d_f", res_flag, 4'hD);
        idle(3, 1'b1, 1'b0);

        // async reset with three tags outstanding and the slot stalled
        step(2'b11, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b11, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b11, rkey(), 8'($urandom), 1'b1, 1'b0, 4'h0);
        step(2'b00, '0, '0, 1'b1, 1'b0, 4'h0);
        step(2'b00, '0, '0, 1'b0, 1'b0, 4'h0);
        chk("pre_rst_valid", db_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_db_valid", db_valid, 1'b0);
        chk("arst_db_key", db_key, 96'h0);
        chk("arst_res_valid", res_valid, 2'b00);
        chk("arst_drop", drop_pulse, 2'b00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(2'b00, '0, '0, 1'b1, 1'b1, 4'h5);
        chk("late_resp", res_valid, 2'b00);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic rdy, ov;
            rdy = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ov  = ($urandom_range(0, 2) == 0);
            step(2'($urandom), rkey(), 8'($urandom), rdy, ov, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
